// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war scoreboard.
//   tow_state_e : match-progress states used by tow_scoreboard
//   SEG_*       : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    HOLD    = 2'd1,
    RESTART = 2'd2,
    DONE    = 2'd3
  } tow_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/tow_scoreboard_if.sv
// Win interface between the playfield (two tow_score instances) and the
// scoreboard, plus the scoreboard's display/status outputs.
//   win1, win2   : per-player win levels, held until the playfield restarts
//   round_reset  : one-cycle restart pulse back to the playfield
//   game_over    : match decided
//   hex_p1/hex_p2: active-low score digits (HEX5 / HEX0)
// master = playfield side, slave = scoreboard side.
interface tow_scoreboard_if;

  logic       win1;
  logic       win2;
  logic       round_reset;
  logic       game_over;
  logic [6:0] hex_p1;
  logic [6:0] hex_p2;

  modport master (
    output win1, win2,
    input  round_reset, game_over, hex_p1, hex_p2
  );

  modport slave (
    input  win1, win2,
    output round_reset, game_over, hex_p1, hex_p2
  );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational 4-bit to active-low seven-segment decoder.
//   digit : value to show; 0-9 decoded, anything else blanks the display
//   seg   : active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
  import tow_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tow_scoreboard.sv
// Tug-of-war round/match scoreboard.
//   clk   : game clock
//   reset : asynchronous, active-high
//   bus   : slave side of tow_scoreboard_if (win levels in; round_reset,
//           game_over and the two score digits out)
// Counts rounds on the rising edge of each player's win level, shows the
// finished round for HOLD_CYCLES cycles, then pulses round_reset for one
// cycle. Reaching MAX_WINS ends the match; only reset leaves that state.
//
// state   | meaning
// PLAY    | round in progress, waiting for a win edge
// HOLD    | round finished, result on display, timer counting down
// RESTART | round_reset high for this single cycle
// DONE    | match decided, scores frozen, game_over high
module tow_scoreboard
  import tow_pkg::*;
#(
  parameter int MAX_WINS    = 7,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  tow_scoreboard_if.slave  bus
);

  localparam logic [3:0]       MAX_W4    = 4'(MAX_WINS);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  tow_state_e       state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [3:0]       score1, score1_nxt;
  logic [3:0]       score2, score2_nxt;
  logic             win1_q, win2_q;
  logic             rise1, rise2;

  // Edge registers run in every state so a level held through HOLD/RESTART
  // is already "seen" when PLAY resumes and cannot score twice.
  assign rise1 = bus.win1 & ~win1_q;
  assign rise2 = bus.win2 & ~win2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= PLAY;
      timer  <= '0;
      score1 <= '0;
      score2 <= '0;
      win1_q <= 1'b0;
      win2_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      score1 <= score1_nxt;
      score2 <= score2_nxt;
      win1_q <= bus.win1;
      win2_q <= bus.win2;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    score1_nxt = score1;
    score2_nxt = score2;
    case (state)
      PLAY: begin
        if (rise1 && rise2) begin
          // Simultaneous wins are a drawn round: no point, normal hold.
          state_nxt = HOLD;
          timer_nxt = HOLD_LOAD;
        end else if (rise1) begin
          score1_nxt = (score1 < MAX_W4) ? score1 + 4'd1 : score1;
          if (score1_nxt == MAX_W4) begin
            state_nxt = DONE;
          end else begin
            state_nxt = HOLD;
            timer_nxt = HOLD_LOAD;
          end
        end else if (rise2) begin
          score2_nxt = (score2 < MAX_W4) ? score2 + 4'd1 : score2;
          if (score2_nxt == MAX_W4) begin
            state_nxt = DONE;
          end else begin
            state_nxt = HOLD;
            timer_nxt = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (timer == '0) begin
          state_nxt = RESTART;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      RESTART: state_nxt = PLAY;
      DONE:    state_nxt = DONE;
      default: state_nxt = PLAY;
    endcase
  end

  assign bus.round_reset = (state == RESTART);
  assign bus.game_over   = (state == DONE);

  seg7_decoder u_hex_p1 (
    .digit (score1),
    .seg   (bus.hex_p1)
  );

  seg7_decoder u_hex_p2 (
    .digit (score2),
    .seg   (bus.hex_p2)
  );

endmodule

// File: tb/tb_tow_scoreboard.sv
// Self-checking bench for tow_scoreboard: directed scenarios followed by
// randomized win levels, all compared against a cycle-count based model.
module tb_tow_scoreboard;

  localparam int H  = 4;
  localparam int MW = 7;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tow_scoreboard_if bus();

  tow_scoreboard #(
    .MAX_WINS    (MW),
    .HOLD_CYCLES (H),
    .CNT_W       (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                7'b0110000, 7'b0011001, 7'b0010010,
                                7'b0000010, 7'b1111000, 7'b0000000,
                                7'b0010000};

  // Reference model: scores, match flag, and the edge index at which the
  // current round's restart pulse is due. A new win only counts once the
  // edge after that pulse has passed.
  int m_s1, m_s2, m_rr, cyc;
  bit m_over, m_p1, m_p2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int d);
    return (d >= 0 && d <= 9) ? seg_tab[d] : 7'b1111111;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_over = 0; m_rr = -100; m_p1 = 0; m_p2 = 0;
  endtask

  task automatic model_edge(input bit w1, input bit w2);
    bit r1, r2;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    r1 = w1 && !m_p1;
    r2 = w2 && !m_p2;
    m_p1 = w1;
    m_p2 = w2;
    if (!m_over && cyc > m_rr + 1 && (r1 || r2)) begin
      if (r1 && r2) begin
        m_rr = cyc + H;
      end else if (r1) begin
        m_s1++;
        if (m_s1 == MW) m_over = 1; else m_rr = cyc + H;
      end else begin
        m_s2++;
        if (m_s2 == MW) m_over = 1; else m_rr = cyc + H;
      end
    end
  endtask

  task automatic check_all();
    check("hex_p1",      bus.hex_p1,      exp_seg(m_s1));
    check("hex_p2",      bus.hex_p2,      exp_seg(m_s2));
    check("round_reset", bus.round_reset, (cyc == m_rr) ? 1 : 0);
    check("game_over",   bus.game_over,   m_over ? 1 : 0);
  endtask

  task automatic step(input bit w1, input bit w2);
    @(negedge clk);
    bus.win1 = w1;
    bus.win2 = w2;
    @(posedge clk);
    model_edge(w1, w2);
    #1;
    check_all();
  endtask

  task automatic sync_reset();
    @(negedge clk);
    reset = 1'b1;
    step(0, 0);
    step(0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic async_reset_check();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_hex_p1", bus.hex_p1,      7'b1000000);
    check("async_hex_p2", bus.hex_p2,      7'b1000000);
    check("async_rr",     bus.round_reset, 1'b0);
    check("async_go",     bus.game_over,   1'b0);
    step(0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit w1, w2;
    reset    = 1'b1;
    bus.win1 = 1'b0;
    bus.win2 = 1'b0;
    cyc      = 0;
    model_reset();

    // Idle after reset.
    sync_reset();
    repeat (5) step(0, 0);

    // Win1 held high: one point, one restart pulse, no retrigger.
    step(1, 0);
    check("s2_first_edge", bus.hex_p1, 7'b1111001);
    repeat (11) step(1, 0);
    check("s2_no_recount", bus.hex_p1, 7'b1111001);
    repeat (3) step(0, 0);

    // Tie round.
    repeat (8) step(1, 1);
    repeat (2) step(0, 0);
    check("s3_tie_p1", bus.hex_p1, 7'b1111001);
    check("s3_tie_p2", bus.hex_p2, 7'b1000000);

    // Async reset mid-hold with score1 = 2.
    step(1, 0);
    step(1, 0);
    check("s5_score1_two", bus.hex_p1, 7'b0100100);
    async_reset_check();
    repeat (3) step(0, 0);

    // Player 2 wins the match with isolated pulses.
    for (int i = 0; i < MW; i++) begin
      step(0, 1);
      repeat (H + 2) step(0, 0);
    end
    check("s4_hex_p2_seven", bus.hex_p2, 7'b1111000);
    check("s4_game_over",    bus.game_over, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      step(0, 0);
      step(0, 1);
      step(1, 1);
      step(0, 0);
    end
    check("s4_frozen_p2", bus.hex_p2, 7'b1111000);

    // Win2 held across the restart, then re-raised.
    sync_reset();
    repeat (10) step(0, 1);
    step(0, 0);
    step(0, 1);
    check("s6_second_point", bus.hex_p2, 7'b0100100);
    repeat (H + 2) step(0, 0);

    // Randomized win levels, with occasional mid-run async resets.
    for (int it = 0; it < 4; it++) begin
      sync_reset();
      w1 = 0;
      w2 = 0;
      for (int k = 0; k < 300; k++) begin
        if ($urandom_range(3) == 0) w1 = ~w1;
        if ($urandom_range(3) == 0) w2 = ~w2;
        step(w1, w2);
        if ($urandom_range(149) == 0) begin
          async_reset_check();
          w1 = 0;
          w2 = 0;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
